// File: rtl/amp_frontend_pkg.sv
// amp_frontend_pkg
//   Shared definitions for the S/PDIF front end: the lock-detector FSM state
//   encoding, default timing constants used by spdif_lock_detect,
//   amp_state_control and the benches, and a small arithmetic helper.
package amp_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam int unsigned DEF_MIN_UNIT = 3;   // smallest unit interval, clk cycles
  localparam int unsigned DEF_MAX_UNIT = 20;  // largest unit interval, clk cycles
  localparam int unsigned DEF_TIMEOUT  = 96;  // edge-free cycles treated as dropout

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/spdif_interval_meter.sv
// spdif_interval_meter
//   Measures the spacing between line transitions and tracks the minimum
//   spacing over windows of 2^WIN_LOG2 measurements.
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   edge_i        one-cycle pulse per line transition
//   window_done_o high in the cycle of the edge that closes a window
//   win_min_o     minimum interval of the closing window (valid with window_done_o)
//   dropout_o     high in the cycle where the interval counter hits TIMEOUT
//                 without an edge
module spdif_interval_meter
  import amp_frontend_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       edge_i,
  output logic       window_done_o,
  output logic [7:0] win_min_o,
  output logic       dropout_o
);

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  logic [7:0]          ivl_q, ivl_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          min_q, min_d;
  // Set by the first edge of a stream; edges only measure while it is set.
  logic                run_q, run_d;

  logic       meas;
  logic [7:0] min_now;

  always_comb begin
    dropout_o     = (ivl_q == TIMEOUT_L) && !edge_i;
    meas          = edge_i && run_q;
    min_now       = (ivl_q < min_q) ? ivl_q : min_q;
    window_done_o = meas && (cnt_q == '1);
    win_min_o     = min_now;
  end

  always_comb begin
    ivl_d = ivl_q;
    cnt_d = cnt_q;
    min_d = min_q;
    run_d = run_q;

    if (edge_i) begin
      ivl_d = 8'd1;
    end else if (ivl_q != 8'hFF) begin
      ivl_d = ivl_q + 8'd1;
    end

    if (dropout_o) begin
      run_d = 1'b0;
      cnt_d = '0;
      min_d = '1;
    end else if (edge_i) begin
      run_d = 1'b1;
      if (meas) begin
        cnt_d = cnt_q + WIN_LOG2'(1);
        min_d = window_done_o ? '1 : min_now;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ivl_q <= '0;
      cnt_q <= '0;
      min_q <= '1;
      run_q <= 1'b0;
    end else begin
      ivl_q <= ivl_d;
      cnt_q <= cnt_d;
      min_q <= min_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/spdif_lock_detect.sv
// spdif_lock_detect
//   Decides whether a stable S/PDIF biphase stream is present by comparing the
//   minimum transition spacing of consecutive measurement windows. Lock needs
//   LOCK_WINDOWS consecutive good comparisons; a bad window or a line dropout
//   drops it.
//   Optional build macro SPDIF_LOCK_HYST_EN: while locked, only UNLOCK_WINDOWS
//   consecutive bad windows unlock (dropout still unlocks at once).
// Ports:
//   clk_in           system clock
//   reset            asynchronous active-low reset
//   edge_in          one-cycle pulse per line transition
//   audio_locked_out stream locked (registered)
//   lock_lost_out    one-cycle pulse on leaving LOCKED
//   unit_period_out  accepted unit interval in clk cycles, meaningful while locked
module spdif_lock_detect
  import amp_frontend_pkg::*;
#(
  parameter int unsigned WIN_LOG2       = 8,
  parameter int unsigned MIN_UNIT       = DEF_MIN_UNIT,
  parameter int unsigned MAX_UNIT       = DEF_MAX_UNIT,
  parameter int unsigned TOL            = 1,
  parameter int unsigned LOCK_WINDOWS   = 4,
  parameter int unsigned UNLOCK_WINDOWS = 3,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       edge_in,
  output logic       audio_locked_out,
  output logic       lock_lost_out,
  output logic [7:0] unit_period_out
);

  // One counter serves as good_cnt in ACQUIRE and bad_cnt in LOCKED; the two
  // are never live at the same time, so it is sized for the larger threshold.
  localparam int unsigned CNT_MAX = (LOCK_WINDOWS > UNLOCK_WINDOWS) ? LOCK_WINDOWS
                                                                     : UNLOCK_WINDOWS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOCK_TH = CW'(LOCK_WINDOWS);
  localparam logic [7:0]    MIN_L   = 8'(MIN_UNIT);
  localparam logic [7:0]    MAX_L   = 8'(MAX_UNIT);
  localparam logic [7:0]    TOL_L   = 8'(TOL);
`ifdef SPDIF_LOCK_HYST_EN
  localparam logic [CW-1:0] UNLOCK_TH = CW'(UNLOCK_WINDOWS);
`endif

  lock_state_e   state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]    prev_min_q, prev_min_d;
  logic          prev_valid_q, prev_valid_d;
  logic [7:0]    unit_q, unit_d;
  logic          locked_q, locked_d;
  logic          lost_q, lost_d;

  logic          window_done;
  logic [7:0]    win_min;
  logic          dropout;
  logic          win_good;
  logic [CW-1:0] cnt_inc;

  spdif_interval_meter #(
    .WIN_LOG2 (WIN_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) u_meter (
    .clk_i         (clk_in),
    .rst_ni        (reset),
    .edge_i        (edge_in),
    .window_done_o (window_done),
    .win_min_o     (win_min),
    .dropout_o     (dropout)
  );

  always_comb begin
    win_good = (win_min >= MIN_L) && (win_min <= MAX_L) && prev_valid_q &&
               (abs_diff8(win_min, prev_min_q) <= TOL_L);
    cnt_inc  = win_cnt_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    prev_min_d   = prev_min_q;
    prev_valid_d = prev_valid_q;
    unit_d       = unit_q;
    lost_d       = 1'b0;

    if (dropout) begin
      state_d      = IDLE;
      win_cnt_d    = '0;
      prev_valid_d = 1'b0;
      prev_min_d   = '0;
      unit_d       = '0;
      lost_d       = (state_q == LOCKED);
    end else begin
      if (window_done) begin
        prev_min_d   = win_min;
        prev_valid_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (edge_in) begin
            state_d   = ACQUIRE;
            win_cnt_d = '0;
          end
        end

        ACQUIRE: begin
          if (window_done) begin
            if (!win_good) begin
              win_cnt_d = '0;
            end else if (cnt_inc == LOCK_TH) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              unit_d    = win_min;
            end else begin
              win_cnt_d = cnt_inc;
            end
          end
        end

        LOCKED: begin
          if (window_done) begin
            if (win_good) begin
              unit_d    = win_min;
              win_cnt_d = '0;
            end else begin
`ifdef SPDIF_LOCK_HYST_EN
              if (cnt_inc == UNLOCK_TH) begin
                state_d   = ACQUIRE;
                win_cnt_d = '0;
                lost_d    = 1'b1;
              end else begin
                win_cnt_d = cnt_inc;
              end
`else
              state_d   = ACQUIRE;
              win_cnt_d = '0;
              lost_d    = 1'b1;
`endif
            end
          end
        end

        default: begin
          state_d   = IDLE;
          win_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      prev_min_q   <= '0;
      prev_valid_q <= 1'b0;
      unit_q       <= '0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      prev_min_q   <= prev_min_d;
      prev_valid_q <= prev_valid_d;
      unit_q       <= unit_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

  assign audio_locked_out = locked_q;
  assign lock_lost_out    = lost_q;
  assign unit_period_out  = unit_q;

endmodule

// File: tb/tb_spdif_lock_detect.sv
// tb_spdif_lock_detect
//   Directed bench for spdif_lock_detect with 16-measurement windows.
module tb_spdif_lock_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       edge_in = 1'b0;
  logic       locked;
  logic       lost;
  logic [7:0] unit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spdif_lock_detect #(
    .WIN_LOG2 (4)
  ) dut (
    .clk_in           (clk),
    .reset            (rst_n),
    .edge_in          (edge_in),
    .audio_locked_out (locked),
    .lock_lost_out    (lost),
    .unit_period_out  (unit)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle edge pulse exactly `gap` cycles after the previous one.
  task automatic edge_after(input int gap);
    repeat (gap - 1) @(negedge clk);
    edge_in = 1'b1;
    @(negedge clk);
    edge_in = 1'b0;
  endtask

  // Biphase-like spacing: mostly u, some 2u, preamble-style 3u; minimum is u.
  task automatic stream(input int n, input int u);
    for (int i = 0; i < n; i++)
      edge_after((i % 8 == 0) ? 3 * u : ((i % 3 == 1) ? 2 * u : u));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_locked", locked, 1'b0);
    chk1("rst_lost", lost, 1'b0);
    chk8("rst_unit", unit, 8'd0);
    rst_n = 1'b1;

    // Clean unit-8 stream: first edge + 5 windows of 16 measurements.
    stream(65, 8);
    chk1("acq_after_w4", locked, 1'b0);
    stream(15, 8);
    chk1("acq_before_w5_close", locked, 1'b0);
    stream(1, 8);
    chk1("lock_w5", locked, 1'b1);
    chk8("lock_unit8", unit, 8'd8);

    // Edge exactly at ivl == TIMEOUT is a normal measurement.
    edge_after(96);
    chk1("edge_at_timeout_locked", locked, 1'b1);
    chk1("edge_at_timeout_nolost", lost, 1'b0);
    stream(15, 8);
    chk1("w6_locked", locked, 1'b1);
    chk8("w6_unit", unit, 8'd8);

    // Dropout: lock falls 97 cycles after the last edge.
    repeat (95) @(negedge clk);
    chk1("pre_dropout_locked", locked, 1'b1);
    @(negedge clk);
    chk1("dropout_locked", locked, 1'b0);
    chk1("dropout_lost", lost, 1'b1);
    chk8("dropout_unit", unit, 8'd0);
    @(negedge clk);
    chk1("dropout_lost_pulse_end", lost, 1'b0);

    // Saturated ivl: next edge only restarts, so lock needs 81 edges again.
    repeat (300) @(negedge clk);
    stream(80, 8);
    chk1("sat_no_lock_80", locked, 1'b0);
    stream(1, 8);
    chk1("sat_lock_81", locked, 1'b1);
    chk8("sat_unit8", unit, 8'd8);

    // Rate change to unit 4.
`ifdef SPDIF_LOCK_HYST_EN
    stream(16, 4);
    chk1("hyst_bad1_locked", locked, 1'b1);
    chk8("hyst_bad1_unit", unit, 8'd8);
    stream(16, 8);
    chk1("hyst_bad2_locked", locked, 1'b1);
    chk1("hyst_bad2_nolost", lost, 1'b0);
    stream(16, 4);
    chk1("hyst_bad3_locked", locked, 1'b0);
    chk1("hyst_bad3_lost", lost, 1'b1);
`else
    stream(15, 4);
    chk1("rate_mid_locked", locked, 1'b1);
    stream(1, 4);
    chk1("rate_close_locked", locked, 1'b0);
    chk1("rate_close_lost", lost, 1'b1);
`endif
    stream(48, 4);
    chk1("relock4_after3", locked, 1'b0);
    stream(16, 4);
    chk1("relock4_locked", locked, 1'b1);
    chk8("relock4_unit", unit, 8'd4);

    // Dropout from unit-4 lock.
    repeat (96) @(negedge clk);
    chk1("drop4_locked", locked, 1'b0);
    chk1("drop4_lost", lost, 1'b1);
    chk8("drop4_unit", unit, 8'd0);

    // Edges every 2 cycles are below MIN_UNIT: never lock.
    edge_after(2);
    for (int w = 0; w < 6; w++) begin
      repeat (16) edge_after(2);
      chk1($sformatf("fast_w%0d_locked", w), locked, 1'b0);
    end
    chk8("fast_unit", unit, 8'd0);

    // Back to unit 8: first window compares against min 2 and is bad.
    stream(64, 8);
    chk1("from_fast_acq", locked, 1'b0);
    stream(16, 8);
    chk1("from_fast_locked", locked, 1'b1);
    chk8("from_fast_unit", unit, 8'd8);

    // Asynchronous reset mid-window while locked.
    stream(7, 8);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_locked", locked, 1'b0);
    chk1("async_rst_lost", lost, 1'b0);
    chk8("async_rst_unit", unit, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stream(80, 8);
    chk1("post_rst_80", locked, 1'b0);
    stream(1, 8);
    chk1("post_rst_lock", locked, 1'b1);
    chk8("post_rst_unit", unit, 8'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_lock_detect.md
# spdif_lock_detect

Measures the spacing of S/PDIF line transitions and decides whether a valid, stable biphase stream is present. Sits between the `spdif_decoder` edge-detect output and `amp_state_control`, and drives its `audio_locked_in` input. Lock is declared only after several consecutive measurement windows agree on the same unit interval. Lock is dropped on line dropout or on an unstable window.

## Interface
Parameters:
- `WIN_LOG2`, 8 — log2 of edges per measurement window (256 edges).
- `MIN_UNIT`, 3 — smallest acceptable unit interval, in clk cycles.
- `MAX_UNIT`, 20 — largest acceptable unit interval, in clk cycles.
- `TOL`, 1 — maximum allowed |min − prev_min| between consecutive windows.
- `LOCK_WINDOWS`, 4 — consecutive good comparisons required to lock.
- `UNLOCK_WINDOWS`, 3 — consecutive bad windows required to unlock (hysteresis build only).
- `TIMEOUT`, 96 — edge-free cycles that count as dropout; must be ≤255.

Ports:
- `clk_in` input 1 — system clock (48 MHz nominal).
- `reset` input 1 — asynchronous, active-low reset.
- `edge_in` input 1 — one-cycle pulse per rx transition, from `spdif_decoder.edgedetect`.
- `audio_locked_out` output 1 — stream locked. Registered.
- `lock_lost_out` output 1 — one-cycle pulse on the LOCKED→non-locked transition.
- `unit_period_out` output 8 — accepted unit interval in clk cycles. Meaningful only while locked.

## Operation
- Interval counter `ivl` (8 bit) increments every cycle and saturates at 255.
- On `edge_in`: the measured interval is `ivl`, and `ivl` is set to 1. Example: edges at cycles t and t+8 measure 8.
- The first edge after reset or after IDLE only starts `ivl`; it produces no measurement.
- Window logic:
  - `win_min` tracks the minimum measured interval over 2^WIN_LOG2 measurements.
  - The edge carrying the last measurement closes the window.
  - `win_min` is then reloaded to 255.
- A window is good when both hold:
  - MIN_UNIT ≤ `win_min` ≤ MAX_UNIT;
  - a `prev_min` exists and |`win_min` − `prev_min`| ≤ TOL.
- At every window close, `prev_min` ← `win_min`.
- FSM states:
  - IDLE — no measurements.
    - First edge → ACQUIRE.
  - ACQUIRE — `good_cnt` counts consecutive good windows.
    - Bad window: `good_cnt` ← 0.
    - `good_cnt` reaching LOCK_WINDOWS → LOCKED; `unit_period_out` ← `win_min`.
  - LOCKED
    - Good window: `unit_period_out` ← `win_min`.
    - Bad window → ACQUIRE; `good_cnt` ← 0; pulse `lock_lost_out`.
- Dropout: `ivl` == TIMEOUT with no edge in that cycle.
  - From any state → IDLE.
  - Clears `prev_min`, `good_cnt` and `unit_period_out`.
  - If leaving LOCKED, pulse `lock_lost_out`.
- Simultaneous events: an edge in the same cycle as `ivl` == TIMEOUT is a normal edge, not a dropout.
- An edge arriving while `ivl` is saturated (longer than TIMEOUT) is treated as the first edge from IDLE.
- Reset values: state IDLE; `audio_locked_out` 0; `lock_lost_out` 0; `unit_period_out` 0; `ivl` 0; `win_min` 255; `prev_min` invalid.
- Reset asserted mid-window clears all state immediately and asynchronously.

## Timing
- `audio_locked_out` rises the cycle after the window-closing edge that completes the LOCK_WINDOWS-th good comparison.
- Minimum lock time from first edge: (LOCK_WINDOWS+1) windows. The first window only seeds `prev_min`.
- On a bad window, `audio_locked_out` falls one cycle after the window-closing edge.
- On dropout, `audio_locked_out` falls one cycle after the cycle where `ivl` == TIMEOUT.
- `lock_lost_out` is high in the same cycle that `audio_locked_out` first reads 0.
- `unit_period_out` updates in the same cycle as the state update.

## Configuration
- `SPDIF_LOCK_HYST_EN` defined:
  - LOCKED keeps `bad_cnt`; a good window clears it.
  - Unlock occurs only when `bad_cnt` reaches UNLOCK_WINDOWS.
  - Dropout still unlocks immediately.
- Not defined: a single bad window unlocks, and `UNLOCK_WINDOWS` is unused.

## Structure
- `amp_frontend_pkg` holds:
  - the FSM state enum (IDLE, ACQUIRE, LOCKED);
  - default constants for MIN_UNIT, MAX_UNIT and TIMEOUT, so `amp_state_control` and benches share them.
- Sub-module `spdif_interval_meter` holds the `ivl` counter, window edge count and `win_min` tracking. It outputs `window_done`, `win_min` and `dropout`.
- The FSM and lock/unlock counters stay in `spdif_lock_detect`.

## Test plan
- Clean 48 kHz stream (edges every 8 or 16 cycles, preamble gaps of 24) → `audio_locked_out` rises one cycle after the close of the 5th window; `unit_period_out` = 8.
- Locked stream, then edges stop → `audio_locked_out` = 0 and `lock_lost_out` pulses exactly 97 cycles after the last edge; `unit_period_out` = 0.
- Locked at unit 8, one window switches to unit 4 (96 kHz), non-hysteresis build → unlock at that window close. Relock at `unit_period_out` = 4 after 4 further good windows.
- Same as above with `SPDIF_LOCK_HYST_EN` defined → stays locked through 2 alternating bad windows; unlocks on the 3rd consecutive bad window.
- Edges every 2 cycles (below MIN_UNIT) → never locks; `good_cnt` stays 0.
- Reset asserted mid-window while locked → all outputs 0 asynchronously. After release, lock is reacquired in 5 windows.
